// File: rtl/conv_rdma_v2_pkg.sv
// Shared types, derived widths and descriptor field offsets for the conv read-DMA.
package conv_rdma_pkg;

  localparam int unsigned AW_DEF = 14;
  localparam int unsigned SW_DEF = 7;
  localparam int unsigned NB_DEF = 2;

  function automatic int unsigned calc_bw(input int unsigned nb);
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

  function automatic int unsigned desc_w(input int unsigned aw, input int unsigned sw,
                                         input int unsigned bw);
    return 4 * aw + 3 * sw + bw;
  endfunction

  localparam int unsigned BW    = calc_bw(NB_DEF);
  localparam int unsigned DESCW = desc_w(AW_DEF, SW_DEF, BW);

  // LSB offsets of each descriptor field; base sits at bit 0
  function automatic int unsigned off_size0(input int unsigned aw);
    return aw;
  endfunction
  function automatic int unsigned off_step0(input int unsigned aw, input int unsigned sw);
    return aw + sw;
  endfunction
  function automatic int unsigned off_size1(input int unsigned aw, input int unsigned sw);
    return 2 * aw + sw;
  endfunction
  function automatic int unsigned off_step1(input int unsigned aw, input int unsigned sw);
    return 2 * aw + 2 * sw;
  endfunction
  function automatic int unsigned off_size2(input int unsigned aw, input int unsigned sw);
    return 3 * aw + 2 * sw;
  endfunction
  function automatic int unsigned off_step2(input int unsigned aw, input int unsigned sw);
    return 3 * aw + 3 * sw;
  endfunction
  function automatic int unsigned off_bank(input int unsigned aw, input int unsigned sw);
    return 4 * aw + 3 * sw;
  endfunction

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

endpackage

// File: rtl/conv_rdma_v2_if.sv
// Descriptor, bank read and output stream bundle of the conv read-DMA.
interface conv_rdma_v2_if #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8,
  parameter int unsigned DN = 8,
  parameter int unsigned NB = 2,
  parameter int unsigned SW = 7
);
  import conv_rdma_pkg::*;

  localparam int unsigned BANK_W = calc_bw(NB);
  localparam int unsigned DESC_W = desc_w(AW, SW, BANK_W);

  logic [DESC_W-1:0]     desc_data;
  logic                  desc_valid;
  logic                  desc_ready;
  logic [AW-1:0]         bank_addr;
  logic [NB-1:0]         bank_addr_valid;
  logic [NB-1:0]         bank_addr_ready;
  logic [NB*DN*DW-1:0]   bank_data;
  logic [NB-1:0]         bank_data_valid;
  logic [NB-1:0]         bank_data_ready;
  logic [DN*DW-1:0]      s_data;
  logic                  s_first;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    input  desc_data, desc_valid, bank_addr_ready, bank_data, bank_data_valid, s_ready,
    output desc_ready, bank_addr, bank_addr_valid, bank_data_ready,
           s_data, s_first, s_last, s_valid
  );

  modport slave (
    output desc_data, desc_valid, bank_addr_ready, bank_data, bank_data_valid, s_ready,
    input  desc_ready, bank_addr, bank_addr_valid, bank_data_ready,
           s_data, s_first, s_last, s_valid
  );

endinterface

// File: rtl/conv_rdma_v2_route_fifo.sv
// Route FIFO: remembers {bank, first, last} of each issued read so data returns in order.
module rdma_route_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/conv_rdma_v2.sv
// Conv read-DMA: walks a 3-level strided address loop over one bank and
// returns the read beats in issue order through a zero-latency data path.
module conv_rdma_v2
  import conv_rdma_pkg::*;
#(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8,
  parameter int unsigned DN = 8,
  parameter int unsigned NB = 2,
  parameter int unsigned SW = 7,
  parameter int unsigned OD = 4
) (
  input  logic            clk,
  input  logic            rst,
  conv_rdma_v2_if.master  io,
  output logic            busy,
  output logic            err
);
  localparam int unsigned BANK_W = calc_bw(NB);
  localparam int unsigned FW     = BANK_W + 2;
  localparam int unsigned BEAT_W = DN * DW;

  state_t            state, state_n;
  logic [AW-1:0]     step0, step1, step2, addr, row_ptr, plane_ptr;
  logic [SW-1:0]     size0, size1, size2, i0, i1, i2;
  logic [BANK_W-1:0] bank_r, d_bank, head_bank;
  logic              d_legal, desc_fire, issue, first_beat, last_beat;
  logic              addr_rdy_sel, full, empty, pop, s_valid;
  logic [NB-1:0]     addr_valid, data_ready;
  logic [FW-1:0]     head;
  logic [BEAT_W-1:0] s_data;

  assign d_bank     = io.desc_data[off_bank(AW, SW) +: BANK_W];
  assign d_legal    = 32'(d_bank) < NB;
  assign desc_fire  = (state == ST_IDLE) && io.desc_valid;
  assign first_beat = (i0 == '0) && (i1 == '0) && (i2 == '0);
  assign last_beat  = (i0 == size0) && (i1 == size1) && (i2 == size2);
  assign issue      = (state == ST_RUN) && !full && addr_rdy_sel;

  always_comb begin
    addr_valid   = '0;
    addr_rdy_sel = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (bank_r == BANK_W'(k)) begin
        addr_valid[k] = (state == ST_RUN) && !full;
        addr_rdy_sel  = io.bank_addr_ready[k];
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (desc_fire && d_legal) state_n = ST_RUN;
      ST_RUN:  if (issue && last_beat)   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Row/plane pointers hold the start of the current inner loop so each
  // wrap reloads from them instead of multiplying indices by strides.
  always_ff @(posedge clk) begin
    if (rst) begin
      {step0, step1, step2} <= '0;
      {size0, size1, size2} <= '0;
      {i0, i1, i2}          <= '0;
      {addr, row_ptr, plane_ptr} <= '0;
      bank_r <= '0;
      err    <= 1'b0;
    end else if (desc_fire) begin
      addr      <= io.desc_data[AW-1:0];
      row_ptr   <= io.desc_data[AW-1:0];
      plane_ptr <= io.desc_data[AW-1:0];
      size0     <= io.desc_data[off_size0(AW) +: SW];
      step0     <= io.desc_data[off_step0(AW, SW) +: AW];
      size1     <= io.desc_data[off_size1(AW, SW) +: SW];
      step1     <= io.desc_data[off_step1(AW, SW) +: AW];
      size2     <= io.desc_data[off_size2(AW, SW) +: SW];
      step2     <= io.desc_data[off_step2(AW, SW) +: AW];
      bank_r    <= d_bank;
      {i0, i1, i2} <= '0;
      if (!d_legal) err <= 1'b1;
    end else if (issue) begin
      if (i0 != size0) begin
        i0   <= i0 + 1'b1;
        addr <= addr + step0;
      end else if (i1 != size1) begin
        i0      <= '0;
        i1      <= i1 + 1'b1;
        row_ptr <= row_ptr + step1;
        addr    <= row_ptr + step1;
      end else if (i2 != size2) begin
        i0        <= '0;
        i1        <= '0;
        i2        <= i2 + 1'b1;
        plane_ptr <= plane_ptr + step2;
        row_ptr   <= plane_ptr + step2;
        addr      <= plane_ptr + step2;
      end
    end
  end

  rdma_route_fifo #(.WIDTH(FW), .DEPTH(OD)) u_route_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   ({bank_r, first_beat, last_beat}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_bank = head[FW-1:2];

  always_comb begin
    s_data     = '0;
    s_valid    = 1'b0;
    data_ready = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (head_bank == BANK_W'(k)) begin
        s_data        = io.bank_data[k*BEAT_W +: BEAT_W];
        s_valid       = io.bank_data_valid[k] && !empty;
        data_ready[k] = io.s_ready && !empty;
      end
    end
  end

  assign pop                = s_valid && io.s_ready;
  assign io.desc_ready      = (state == ST_IDLE);
  assign io.bank_addr       = addr;
  assign io.bank_addr_valid = addr_valid;
  assign io.bank_data_ready = data_ready;
  assign io.s_data          = s_data;
  assign io.s_valid         = s_valid;
  assign io.s_first         = head[1] && !empty;
  assign io.s_last          = head[0] && !empty;
  assign busy               = (state == ST_RUN) || !empty;

endmodule

// File: tb/tb_conv_rdma_v2.sv
// Scoreboard bench for conv_rdma_v2: expected addresses and beats are queued by
// the stimulus, a monitor with a small bank responder pops and compares them.
module tb_conv_rdma_v2;
  localparam int unsigned AW = 14, DW = 8, DN = 8, NB = 2, SW = 7, OD = 4;
  localparam int unsigned BK_W  = conv_rdma_pkg::calc_bw(NB);
  localparam int unsigned DSC_W = conv_rdma_pkg::desc_w(AW, SW, BK_W);

  typedef struct { int bank; logic [AW-1:0] addr; } areq_t;
  typedef struct { logic [63:0] data; logic first; logic last; } beat_t;
  typedef logic [AW-1:0] alist_t[$];

  logic clk = 1'b0;
  logic rst;
  logic busy, err, busy3, err3;
  always #5 clk = ~clk;

  conv_rdma_v2_if #(.AW(AW), .DW(DW), .DN(DN), .NB(NB), .SW(SW)) if0 ();
  conv_rdma_v2_if #(.AW(AW), .DW(DW), .DN(DN), .NB(3),  .SW(SW)) if3 ();

  conv_rdma_v2 #(.AW(AW), .DW(DW), .DN(DN), .NB(NB), .SW(SW), .OD(OD)) u_dut (
    .clk(clk), .rst(rst), .io(if0), .busy(busy), .err(err)
  );
  conv_rdma_v2 #(.AW(AW), .DW(DW), .DN(DN), .NB(3), .SW(SW), .OD(OD)) u_dut3 (
    .clk(clk), .rst(rst), .io(if3), .busy(busy3), .err(err3)
  );

  int total = 0;
  int bad = 0;
  int issued = 0;
  areq_t exp_addr_q[$];
  beat_t exp_beat_q[$];
  logic [AW-1:0] bq0[$], bq1[$];
  logic [1:0] en;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(int k, logic [AW-1:0] a);
    return {8'(k), 24'h5A5A5A, 18'h0, a};
  endfunction

  function automatic logic [DSC_W-1:0] pack(int bank, int base, int s0, int st0,
                                            int s1, int st1, int s2, int st2);
    return {BK_W'(bank), AW'(st2), SW'(s2), AW'(st1), SW'(s1), AW'(st0), SW'(s0), AW'(base)};
  endfunction

  task automatic expect_addrs(int bank, alist_t al);
    foreach (al[i]) begin
      exp_addr_q.push_back('{bank, al[i]});
      exp_beat_q.push_back('{mkdata(bank, al[i]), (i == 0), (i == al.size() - 1)});
    end
  endtask

  task automatic send_desc(logic [DSC_W-1:0] d);
    bit ok = 0;
    @(negedge clk);
    if0.desc_data  = d;
    if0.desc_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #3;
      if (if0.desc_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if0.desc_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL desc_handshake: desc_ready never high, required 1");
    end
  endtask

  task automatic wait_drain(string name, int budget);
    bit ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #3;
      if (exp_addr_q.size() == 0 && exp_beat_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk({"drain_", name}, 64'(ok), 64'd1);
  endtask

  // Bank responder and monitor; samples 2 time units after the falling edge.
  initial begin : mon
    beat_t e;
    areq_t ea;
    forever begin
      @(negedge clk); #1;
      if0.bank_data_valid[0] = en[0] && (bq0.size() > 0);
      if0.bank_data[63:0]    = (bq0.size() > 0) ? mkdata(0, bq0[0]) : '0;
      if0.bank_data_valid[1] = en[1] && (bq1.size() > 0);
      if0.bank_data[127:64]  = (bq1.size() > 0) ? mkdata(1, bq1[0]) : '0;
      #1;
      if (!rst) begin
        if (if0.s_valid && if0.s_ready) begin
          if (exp_beat_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got %0h, required no beat", if0.s_data);
          end else begin
            e = exp_beat_q.pop_front();
            chk("beat_data",  if0.s_data, e.data);
            chk("beat_first", 64'(if0.s_first), 64'(e.first));
            chk("beat_last",  64'(if0.s_last),  64'(e.last));
          end
        end
        if (if0.bank_data_valid[0] && if0.bank_data_ready[0]) void'(bq0.pop_front());
        if (if0.bank_data_valid[1] && if0.bank_data_ready[1]) void'(bq1.pop_front());
        for (int k = 0; k < NB; k++) begin
          if (if0.bank_addr_valid[k] && if0.bank_addr_ready[k]) begin
            issued++;
            if (k == 0) bq0.push_back(if0.bank_addr);
            else        bq1.push_back(if0.bank_addr);
            if (exp_addr_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_addr: got %0h, required no address", if0.bank_addr);
            end else begin
              ea = exp_addr_q.pop_front();
              chk("addr", 64'(if0.bank_addr), 64'(ea.addr));
              chk("addr_onehot", 64'(if0.bank_addr_valid), 64'd1 << ea.bank);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    alist_t al;
    logic [63:0] held;
    int base_issued;
    rst = 1'b1;
    en  = 2'b11;
    if0.desc_valid = 1'b0; if0.desc_data = '0; if0.s_ready = 1'b1; if0.bank_addr_ready = 2'b11;
    if3.desc_valid = 1'b0; if3.desc_data = '0; if3.s_ready = 1'b1; if3.bank_addr_ready = 3'b111;
    if3.bank_data = '0; if3.bank_data_valid = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_desc_ready", 64'(if0.desc_ready), 64'd1);
    chk("rst_addr_valid", 64'(if0.bank_addr_valid), 64'd0);
    chk("rst_s_valid", 64'(if0.s_valid), 64'd0);
    chk("rst_data_ready", 64'(if0.bank_data_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk); rst = 1'b0;

    // 2-level loop on bank 0
    al = '{14'h100, 14'h101, 14'h102, 14'h120, 14'h121, 14'h122};
    expect_addrs(0, al);
    send_desc(pack(0, 'h100, 2, 1, 1, 'h20, 0, 0));
    wait_drain("loop2", 200);

    // 3-level loop on bank 1
    al = '{14'h010, 14'h012, 14'h210, 14'h212};
    expect_addrs(1, al);
    send_desc(pack(1, 'h010, 1, 2, 0, 0, 1, 'h200));
    wait_drain("loop3", 200);

    // address wrap modulo 2^AW
    al = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    expect_addrs(0, al);
    send_desc(pack(0, 'h3FFE, 3, 1, 0, 0, 0, 0));
    wait_drain("wrap", 200);

    // outstanding limit: bank data withheld
    en = 2'b10;
    base_issued = issued;
    al = '{14'h200, 14'h201, 14'h202, 14'h203, 14'h204, 14'h205};
    expect_addrs(0, al);
    send_desc(pack(0, 'h200, 5, 1, 0, 0, 0, 0));
    repeat (12) @(negedge clk);
    #3;
    chk("od_issued", 64'(issued - base_issued), 64'd4);
    chk("od_addr_valid", 64'(if0.bank_addr_valid), 64'd0);
    chk("od_busy", 64'(busy), 64'd1);
    chk("od_s_valid", 64'(if0.s_valid), 64'd0);
    en = 2'b11;
    wait_drain("od", 200);

    // cross-bank ordering and output backpressure
    en = 2'b01;
    al = '{14'h040, 14'h041};
    expect_addrs(1, al);
    al = '{14'h080, 14'h081};
    expect_addrs(0, al);
    send_desc(pack(1, 'h040, 1, 1, 0, 0, 0, 0));
    send_desc(pack(0, 'h080, 1, 1, 0, 0, 0, 0));
    repeat (6) @(negedge clk);
    #3;
    chk("order_s_valid_held", 64'(if0.s_valid), 64'd0);
    chk("order_ready_head", 64'(if0.bank_data_ready), 64'b10);
    @(negedge clk);
    if0.s_ready = 1'b0;
    en = 2'b11;
    @(negedge clk); #3;
    chk("bp_s_valid", 64'(if0.s_valid), 64'd1);
    held = if0.s_data;
    chk("bp_s_data", held, mkdata(1, 'h40));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #3;
      chk("bp_hold_data", if0.s_data, mkdata(1, 'h40));
      chk("bp_data_ready", 64'(if0.bank_data_ready), 64'd0);
    end
    @(negedge clk);
    if0.s_ready = 1'b1;
    wait_drain("order", 200);

    // illegal bank on a 3-bank instance
    @(negedge clk);
    if3.desc_data  = {2'd3, 63'h0, 14'h020};
    if3.desc_valid = 1'b1;
    #3;
    chk("ill_desc_ready", 64'(if3.desc_ready), 64'd1);
    @(negedge clk);
    if3.desc_valid = 1'b0;
    #3;
    chk("ill_err", 64'(err3), 64'd1);
    chk("ill_busy", 64'(busy3), 64'd0);
    chk("ill_addr_valid", 64'(if3.bank_addr_valid), 64'd0);
    repeat (3) @(negedge clk);
    #3;
    chk("ill_err_sticky", 64'(err3), 64'd1);
    chk("ill_idle", 64'(if3.desc_ready), 64'd1);

    // reset in the middle of a run
    en = 2'b10;
    al = '{14'h300, 14'h301, 14'h302, 14'h303, 14'h304, 14'h305, 14'h306, 14'h307};
    expect_addrs(0, al);
    send_desc(pack(0, 'h300, 7, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #3;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_desc_ready", 64'(if0.desc_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_addr_q.delete();
    exp_beat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    en  = 2'b11;
    #3;
    chk("mid_rst_desc_ready", 64'(if0.desc_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err3", 64'(err3), 64'd0);
    @(negedge clk); #3;
    chk("mid_rst_s_valid", 64'(if0.s_valid), 64'd0);
    chk("mid_rst_data_ready", 64'(if0.bank_data_ready), 64'd0);
    chk("mid_rst_addr_valid", 64'(if0.bank_addr_valid), 64'd0);
    bq0.delete();
    bq1.delete();

    al = '{14'h055, 14'h056};
    expect_addrs(0, al);
    send_desc(pack(0, 'h055, 1, 1, 0, 0, 0, 0));
    wait_drain("post_rst", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
